// File: rtl/uart_rx_buffer_if.sv
// Read-side handshake between the UART receive FIFO and the memory map.
// The FIFO drives ready/r_data; the map drives r_valid to consume a byte.
interface uart_rx_buffer_if;
  logic       ready;
  logic [7:0] r_data;
  logic       r_valid;

  modport master (
    input  ready,
    input  r_data,
    output r_valid
  );

  modport slave (
    output ready,
    output r_data,
    input  r_valid
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// Receive byte FIFO (first-word-fall-through) between UART rx and the map.
// Define UART_RX_OVR_CNT_EN to add the saturating ovr_cnt dropped-byte count.
module uart_rx_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  uart_rx_buffer_if.slave   rd,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overrun,
  input  logic              clr_ovr
`ifdef UART_RX_OVR_CNT_EN
  ,
  output logic [7:0]        ovr_cnt
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO can still push.
  assign pop  = rd.r_valid && !empty;
  assign push = rx_done && (!full || pop);
  assign drop = rx_done && full && !pop;

  assign rd.ready  = !empty;
  assign rd.r_data = empty ? 8'h00 : mem[rd_ptr];

  // Storage is intentionally left uncleared on reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (pop && !push) begin
      count <= count - 1'b1;
    end
  end

  // A new drop outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_OVR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt <= 8'h00;
    end else if (drop) begin
      if (clr_ovr) begin
        ovr_cnt <= 8'h01;
      end else if (ovr_cnt != 8'hFF) begin
        ovr_cnt <= ovr_cnt + 8'd1;
      end
    end else if (clr_ovr) begin
      ovr_cnt <= 8'h00;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: stimulus queues expected bytes,
// a negedge monitor checks every consumed byte against the queue.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [4:0] count;
  logic       full;
  logic       overrun;
  logic       clr_ovr;
`ifdef UART_RX_OVR_CNT_EN
  logic [7:0] ovr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [$];

  uart_rx_buffer_if rd ();

  uart_rx_buffer #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rd      (rd.slave),
    .count   (count),
    .full    (full),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
`ifdef UART_RX_OVR_CNT_EN
    ,
    .ovr_cnt (ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: a byte is consumed when r_valid meets ready at the next edge.
  always @(negedge clk) begin
    if (!rst && rd.r_valid && rd.ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got=%0h want=none",
                 rd.r_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd.r_data !== e) begin
          bad++;
          $display("FAIL pop_data: got=%0h want=%0h",
                   rd.r_data, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    rx_data = b;
    rx_done = 1'b1;
    if (acc) exp_q.push_back(b);
    cyc();
    rx_done = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rd.r_valid = 1'b1;
    repeat (n) cyc();
    rd.r_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    rx_data    = 8'h00;
    rx_done    = 1'b0;
    clr_ovr    = 1'b0;
    rd.r_valid = 1'b0;
    cyc();
    rst = 1'b0;
    repeat (5) cyc();
    chk("rst_ready", 32'(rd.ready), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_rdata", 32'(rd.r_data), 0);
`ifdef UART_RX_OVR_CNT_EN
    chk("rst_ovr_cnt", 32'(ovr_cnt), 0);
`endif

    push(8'hA5, 1'b1);
    chk("a5_ready", 32'(rd.ready), 1);
    chk("a5_rdata", 32'(rd.r_data), 32'hA5);
    pop_n(1);
    chk("a5_pop_ready", 32'(rd.ready), 0);
    chk("a5_pop_count", 32'(count), 0);

    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_ovr0", 32'(overrun), 0);
    push(8'h10, 1'b0);
    chk("drop_ovr", 32'(overrun), 1);
    chk("drop_count", 32'(count), 16);
    chk("drop_head", 32'(rd.r_data), 32'h00);
`ifdef UART_RX_OVR_CNT_EN
    chk("drop_ovr_cnt", 32'(ovr_cnt), 1);
`endif
    clr_ovr = 1'b1;
    cyc();
    clr_ovr = 1'b0;
    chk("clr_ovr", 32'(overrun), 0);
`ifdef UART_RX_OVR_CNT_EN
    chk("clr_ovr_cnt", 32'(ovr_cnt), 0);
`endif
    pop_n(16);
    chk("drain_count", 32'(count), 0);
    chk("drain_ready", 32'(rd.ready), 0);

    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    rx_data    = 8'h55;
    rx_done    = 1'b1;
    rd.r_valid = 1'b1;
    exp_q.push_back(8'h55);
    cyc();
    rx_done    = 1'b0;
    rd.r_valid = 1'b0;
    chk("both_count", 32'(count), 16);
    chk("both_ovr", 32'(overrun), 0);
    chk("both_head", 32'(rd.r_data), 32'h01);
    pop_n(16);
    chk("both_drain", 32'(count), 0);

    for (int i = 0; i < 40; i++) begin
      push(8'(8'h80 + i), 1'b1);
      pop_n(1);
    end
    chk("wrap_count", 32'(count), 0);

    rx_data    = 8'h3C;
    rx_done    = 1'b1;
    rd.r_valid = 1'b1;
    exp_q.push_back(8'h3C);
    cyc();
    rx_done    = 1'b0;
    rd.r_valid = 1'b0;
    chk("empty_both_count", 32'(count), 1);
    pop_n(1);

    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    chk("pre_rst_count", 32'(count), 3);
    rst     = 1'b1;
    rx_data = 8'hEE;
    rx_done = 1'b1;
    cyc();
    rst     = 1'b0;
    rx_done = 1'b0;
    exp_q.delete();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_ready", 32'(rd.ready), 0);
    push(8'h77, 1'b1);
    chk("post_rst_head", 32'(rd.r_data), 32'h77);
    pop_n(1);
    chk("post_rst_count", 32'(count), 0);

    cyc();
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
